// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 4-digit seven-segment driver.
// Segment encodings are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Entry n is the pattern for hex digit n (packed, so index 15 is leftmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
  } disp_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_display_driver.sv
// Time-multiplexed 4-digit hex display driver with frame-synchronous updates
// so a new value never appears partway through a scan.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          tick;
  disp_t         disp, pend, live;
  logic          pend_vld;
  logic [15:0]   upper;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          blank;

  assign live       = {value, dp_mask, blank_lz};
  assign tick       = (cnt == CW'(TICK_DIV - 1));
  assign frame_done = tick && (idx == 2'd3);

  // Shifting the current digit down to bit 0 also exposes whether it and every
  // digit to its left are zero, which is the leading-zero condition.
  assign upper = disp.value >> {idx, 2'b00};
  assign nib   = upper[3:0];
  assign blank = disp.blank_lz && (idx != 2'd0) && (upper == 16'h0000);

  hex_to_seg u_dec (
    .nibble (nib),
    .seg    (dec)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp       <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      anode      <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;

      // A load landing on the boundary bypasses the buffer entirely.
      if (frame_done) begin
        if (load)          disp <= live;
        else if (pend_vld) disp <= pend;
        pend_vld <= 1'b0;
      end else if (load) begin
        pend     <= live;
        pend_vld <= 1'b1;
      end

      anode <= ~(4'b0001 << idx);
      seg   <= blank ? SEG_BLANK : dec;
      dp    <= ~disp.dp_mask[idx];
    end
  end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter TICK_DIV, default 100000, clock cycles per digit dwell; legal range is 2 or more.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset=0 at a rising edge resets the block.
REQ-004 value  input  16  hex value to display; nibble i drives digit i (digit 0 = rightmost).
REQ-005 load  input  1  single-cycle strobe; captures value, dp_mask and blank_lz.
REQ-006 dp_mask  input  4  decimal-point enables; bit i=1 lights the DP on digit i.
REQ-007 blank_lz  input  1  leading-zero blanking enable.
REQ-008 anode  output  4  digit enables, active-low, one-hot-low while running.
REQ-009 seg  output  7  cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 dp  output  1  decimal-point cathode, active-low.
REQ-011 frame_done  output  1  one-cycle pulse on every frame boundary.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1, assert an internal tick at TICK_DIV-1, then wrap to 0.
REQ-013 Digit index SHALL advance 0->1->2->3->0 on each tick and hold otherwise.
REQ-014 A frame boundary SHALL occur on the tick where the index wraps 3->0; frame_done=1 in exactly that cycle.
REQ-015 load SHALL write value/dp_mask/blank_lz into a pending buffer and set a pending flag; a later load in the same frame overwrites it (last wins).
REQ-016 On a frame boundary with pending set, the display register SHALL take the pending contents and clear pending; without pending it holds.
REQ-017 Load and frame boundary in the same cycle: display register SHALL take the live inputs directly and pending SHALL end cleared.
REQ-018 The display register SHALL change only on frame boundaries (no mid-frame tearing).
REQ-019 anode, seg and dp SHALL be registered and SHALL reflect the digit index and display register with one cycle of latency.
REQ-020 anode SHALL be low only on bit [index].
REQ-021 Hex decode (seg hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-022 With blank_lz=1, digit i>0 SHALL be blanked (seg=7F) when nibbles i..3 are all zero; digit 0 is never blanked.
REQ-023 dp SHALL be 0 when the display dp_mask[index]=1, else 1, independent of blanking.

Reset
REQ-024 On reset: prescaler=0, index=0, display register=0, pending buffer and flag cleared, dp_mask=0, blank_lz=0.
REQ-025 Output reset values: anode=4'b1111, seg=7'h7F, dp=1, frame_done=0.
REQ-026 A reset mid-frame SHALL discard pending data; the cycle after release outputs anode=1110, seg=40.

Structure
REQ-027 Shared package seg_pkg SHALL hold the 16-entry hex-to-segment table, SEG_BLANK=7'h7F and ANODE_OFF=4'hF.
REQ-028 A combinational sub-module hex_to_seg (4-bit nibble in, 7-bit seg out) SHALL implement REQ-021; all other logic is in seg_display_driver.

Verification (TICK_DIV=4)
REQ-029 reset low for 3 cycles -> anode=1111, seg=7F, dp=1 throughout; first cycle after release anode=1110, seg=40; frame_done every 16 cycles.
REQ-030 load value=0x1234 -> after the next frame_done: digit0 seg=19 (anode 1110), digit1 seg=30, digit2 seg=24, digit3 seg=79 (anode 0111).
REQ-031 load 0xAAAA while index=1 -> digits 2,3 of that frame still show old value; all digits seg=08 from the next frame.
REQ-032 blank_lz=1, value=0x0005 -> digits 1-3 seg=7F, digit0 seg=12; value=0x0000 -> digits 1-3 seg=7F, digit0 seg=40; dp_mask=4'b0100 -> dp=0 only on digit 2.
REQ-033 Loads 0x1111 then 0x2222 in one frame -> 0x2222 is displayed; a load coinciding with frame_done is displayed in the frame starting at that boundary.
REQ-034 Reset asserted mid-frame with pending set -> reset outputs next cycle; after release the display shows 0000 and no pending transfer occurs.
